// File: rtl/halt_dump_ctrl_if.sv
// halt_dump_ctrl_if
// Groups every non-clock, non-reset signal of halt_dump_ctrl.
//   master : the dump controller (drives CPU hold, RAM read port, dump stream)
//   slave  : the surroundings (CPU instruction register, RAM data, consumer)
// Signals:
//   instruction   current instruction register contents
//   ext_dump_req  request a dump from RUN, same effect as the halt word
//   ram_rdata     RAM read data
//   dump_ready    consumer accepts dump_data
//   cpu_hold      freezes the CPU
//   adr_override  selects ram_addr onto the RAM address mux
//   ram_addr      dump read address
//   ram_rd_en     one-cycle read strobe
//   dump_data     captured memory word
//   dump_valid    dump_data is valid
//   dump_index    address of the word currently on dump_data
//   dump_done     all words have been accepted
`timescale 1ns/1ps
interface halt_dump_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0] instruction;
    logic              ext_dump_req;
    logic [DATA_W-1:0] ram_rdata;
    logic              dump_ready;
    logic              cpu_hold;
    logic              adr_override;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] dump_data;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_index;
    logic              dump_done;

    modport master (
        input  instruction, ext_dump_req, ram_rdata, dump_ready,
        output cpu_hold, adr_override, ram_addr, ram_rd_en,
               dump_data, dump_valid, dump_index, dump_done
    );

    modport slave (
        output instruction, ext_dump_req, ram_rdata, dump_ready,
        input  cpu_hold, adr_override, ram_addr, ram_rd_en,
               dump_data, dump_valid, dump_index, dump_done
    );
endinterface

// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl
// Watches the instruction register for the halt word (or an external
// request). On halt it freezes the CPU, takes over the RAM address mux and
// streams RAM words 0..DUMP_DEPTH-1 out over a valid/ready port.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    halt_dump_ctrl_if.master (see the interface file for signals);
//          the interface DATA_W/ADDR_W must match this module's parameters
// All outputs are registered.
`timescale 1ns/1ps
module halt_dump_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 16,
    parameter int                DUMP_DEPTH = 256,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(32'h0F00_0000),
    parameter int                RD_LAT     = 1
) (
    input  logic               clk,
    input  logic               reset,
    halt_dump_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HALT    = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Last address to dump. DUMP_DEPTH may equal 2^ADDR_W, so the value is
    // truncated to ADDR_W bits after subtracting; the index stops here and
    // never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);
    localparam logic [2:0]        LAT       = 3'(RD_LAT);

    state_t            state_q;
    logic [ADDR_W-1:0] index_q;
    logic [2:0]        cnt_q;
    logic              cpu_hold_q;
    logic              adr_override_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_rd_en_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              dump_valid_q;
    logic [ADDR_W-1:0] dump_index_q;
    logic              dump_done_q;

    logic [ADDR_W-1:0] index_d;
    logic              halt_seen;

    assign index_d   = index_q + ADDR_W'(1);
    assign halt_seen = (bus.instruction == HALT_WORD) || bus.ext_dump_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            index_q        <= '0;
            cnt_q          <= '0;
            cpu_hold_q     <= 1'b0;
            adr_override_q <= 1'b0;
            ram_addr_q     <= '0;
            ram_rd_en_q    <= 1'b0;
            dump_data_q    <= '0;
            dump_valid_q   <= 1'b0;
            dump_index_q   <= '0;
            dump_done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt_seen) begin
                        state_q        <= ST_HALT;
                        cpu_hold_q     <= 1'b1;
                        adr_override_q <= 1'b1;
                    end
                end

                ST_HALT: begin
                    state_q     <= ST_READ;
                    ram_addr_q  <= index_q;
                    ram_rd_en_q <= 1'b1;
                end

                ST_READ: begin
                    state_q     <= ST_WAIT;
                    ram_rd_en_q <= 1'b0;
                    cnt_q       <= 3'd1;
                end

                // ram_addr stays put while the RAM pipeline fills.
                ST_WAIT: begin
                    if (cnt_q == LAT) begin
                        state_q      <= ST_PRESENT;
                        dump_data_q  <= bus.ram_rdata;
                        dump_index_q <= index_q;
                        dump_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                ST_PRESENT: begin
                    if (dump_valid_q && bus.dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (index_q == LAST_ADDR) begin
                            state_q     <= ST_DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            // Go straight to the next read; the strobe and
                            // address are set here so READ shows them.
                            state_q     <= ST_READ;
                            index_q     <= index_d;
                            ram_addr_q  <= index_d;
                            ram_rd_en_q <= 1'b1;
                        end
                    end
                end

                // Terminal: only reset leaves.
                ST_DONE: begin
                    dump_done_q  <= 1'b1;
                    dump_valid_q <= 1'b0;
                    ram_rd_en_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.adr_override = adr_override_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_rd_en    = ram_rd_en_q;
    assign bus.dump_data    = dump_data_q;
    assign bus.dump_valid   = dump_valid_q;
    assign bus.dump_index   = dump_index_q;
    assign bus.dump_done    = dump_done_q;

endmodule
